// File: rtl/led_pkg.sv
// Shared page constants and step helpers for the LED byte-display page select.
// The display stage uses the same constants for its default branch.
package led_pkg;

  localparam int        PAGE_W     = 4;
  localparam logic [3:0] PAGE_FIRST = 4'd0;
  localparam logic [3:0] PAGE_LAST  = 4'd8;
  localparam logic [3:0] PAGE_FLAGS = 4'd8;

  localparam int NUM_BTN  = 2;
  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_NEXT = 2'd1,
    STEP_PREV = 2'd2
  } step_e;

  function automatic logic [PAGE_W-1:0] page_next(input logic [PAGE_W-1:0] p);
    return (p == PAGE_LAST) ? PAGE_FIRST : p + 4'd1;
  endfunction

  function automatic logic [PAGE_W-1:0] page_prev(input logic [PAGE_W-1:0] p);
    return (p == PAGE_FIRST) ? PAGE_LAST : p - 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton: 2-flop synchroniser, stable-count debounce, and a rise strobe
// taken from the registered debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DB_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level_q;

  // The level flips only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync    <= {sync[0], btn};
      level_q <= level;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= ~level;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/led_page_sel.sv
// Page select for the LED byte-display mux: debounced next/prev buttons plus
// an optional auto-scan timer, stepping through pages 0..8 with wrap-around.
module led_page_sel
  import led_pkg::*;
#(
  parameter int DB_CYCLES   = 1_000_000,
  parameter int SCAN_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              auto_en,
  output logic [PAGE_W-1:0] sela,
  output logic              sel_pulse
);

  localparam int SW = $clog2(SCAN_CYCLES);

  logic [NUM_BTN-1:0] btn_raw, btn_lvl, btn_rise;
  logic [SW-1:0]      scan_cnt;
  logic               auto_q, scan_tc, scan_clr;
  logic [PAGE_W-1:0]  sela_nxt;
  step_e              step;

  assign btn_raw = {btn_prev, btn_next};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn_raw[i]),
      .level (btn_lvl[i]),
      .rise  (btn_rise[i])
    );
  end

  // auto_en is registered so the first auto step lands SCAN_CYCLES after sampling.
  assign scan_tc = auto_q && (scan_cnt == SW'(SCAN_CYCLES - 1));

  always_comb begin
    step     = STEP_NONE;
    scan_clr = |btn_rise;
    if (btn_rise[BTN_NEXT] && !btn_rise[BTN_PREV])      step = STEP_NEXT;
    else if (btn_rise[BTN_PREV] && !btn_rise[BTN_NEXT]) step = STEP_PREV;
    else if (!(|btn_rise) && scan_tc)                   step = STEP_NEXT;
  end

  always_comb begin
    sela_nxt = sela;
    unique case (step)
      STEP_NEXT: sela_nxt = page_next(sela);
      STEP_PREV: sela_nxt = page_prev(sela);
      default:   sela_nxt = sela;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_q    <= 1'b0;
      scan_cnt  <= '0;
      sela      <= PAGE_FIRST;
      sel_pulse <= 1'b0;
    end else begin
      auto_q    <= auto_en;
      if (!auto_q || scan_clr || scan_tc) scan_cnt <= '0;
      else                                scan_cnt <= scan_cnt + 1'b1;
      sela      <= sela_nxt;
      sel_pulse <= (sela_nxt != sela);
    end
  end

endmodule
